id_ex_stage: RTL

ID/EX pipeline register and execute-stage operand selector for the five-stage MIPS pipeline. It sits directly upstream of `alu`. It latches decoded operands and control from ID, and drives `alu.a`, `alu.b`, `alu.op` and `alu.is_sign` with forwarded values. It also detects load-use hazards and returns a stall to ID.

---
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and ID hazard stall.
// Optional feature macro: ID_EX_FORWARD_EN (defined = EX/MEM and MEM/WB forwarding, load-use stall only).
module id_ex_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         id_valid,
    input  logic [W-1:0] id_rs_val,
    input  logic [W-1:0] id_rt_val,
    input  logic [W-1:0] id_imm,
    input  logic [4:0]   id_rs,
    input  logic [4:0]   id_rt,
    input  logic [4:0]   id_rd,
    input  logic         id_use_rs,
    input  logic         id_use_rt,
    input  logic         id_use_imm,
    input  logic [1:0]   id_alu_op,
    input  logic         id_is_sign,
    input  logic         id_reg_write,
    input  logic         id_mem_read,
    input  logic         id_mem_write,
    input  logic         flush,
    input  logic         hold,
    input  logic         exm_reg_write,
    input  logic [4:0]   exm_rd,
    input  logic [W-1:0] exm_result,
    input  logic         wb_reg_write,
    input  logic [4:0]   wb_rd,
    input  logic [W-1:0] wb_result,
    output logic         id_stall,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    output logic         alu_is_sign,
    output logic         ex_valid,
    output logic [4:0]   ex_rd,
    output logic         ex_reg_write,
    output logic         ex_mem_read,
    output logic         ex_mem_write,
    output logic [W-1:0] ex_store_val
);

    typedef struct packed {
        logic         valid;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   rd;
        logic [W-1:0] rs_val;
        logic [W-1:0] rt_val;
        logic [W-1:0] imm;
        logic         use_imm;
        logic [1:0]   op;
        logic         is_sign;
        logic         reg_write;
        logic         mem_read;
        logic         mem_write;
    } ex_state_t;

    ex_state_t    ex_q;
    ex_state_t    ex_d;
    logic         hazard;
    logic [W-1:0] rs_op;
    logic [W-1:0] rt_op;

    // A used, nonzero ID source that names the given destination register.
    function automatic logic src_hit(input logic use_src, input logic [4:0] src,
                                     input logic [4:0] dst);
        return use_src && (src == dst) && (src != 5'd0);
    endfunction

    // NOTE: every path assigns ex_d because it starts from a default; no latch is inferred.
    always_comb begin : next_state
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (hold) begin
            ex_d = ex_q;
        end else if (id_stall) begin
            ex_d = '0;
        end else begin
            ex_d.valid     = id_valid;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.rd        = id_rd;
            ex_d.rs_val    = id_rs_val;
            ex_d.rt_val    = id_rt_val;
            ex_d.imm       = id_imm;
            ex_d.use_imm   = id_use_imm;
            ex_d.op        = id_alu_op;
            ex_d.is_sign   = id_is_sign;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.mem_write = id_mem_write;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

`ifdef ID_EX_FORWARD_EN
    function automatic logic [W-1:0] fwd(input logic [4:0] r, input logic [W-1:0] latched,
                                         input logic exm_we, input logic [4:0] exm_dst,
                                         input logic [W-1:0] exm_val, input logic wb_we,
                                         input logic [4:0] wb_dst, input logic [W-1:0] wb_val);
        if (exm_we && exm_dst == r && r != 5'd0) return exm_val;
        if (wb_we && wb_dst == r && r != 5'd0) return wb_val;
        return latched;
    endfunction

    assign rs_op = fwd(ex_q.rs, ex_q.rs_val, exm_reg_write, exm_rd, exm_result,
                       wb_reg_write, wb_rd, wb_result);
    assign rt_op = fwd(ex_q.rt, ex_q.rt_val, exm_reg_write, exm_rd, exm_result,
                       wb_reg_write, wb_rd, wb_result);

    // Only a load in EX cannot be covered by forwarding.
    assign hazard = ex_q.valid && ex_q.mem_read &&
                    (src_hit(id_use_rs, id_rs, ex_q.rd) || src_hit(id_use_rt, id_rt, ex_q.rd));
`else
    logic unused_nofwd;
    assign unused_nofwd = ^{ex_q.rs, ex_q.rt, exm_result, wb_reg_write, wb_rd, wb_result};

    assign rs_op = ex_q.rs_val;
    assign rt_op = ex_q.rt_val;

    // MEM/WB needs no check: the register file returns the value being written.
    assign hazard = (ex_q.valid && ex_q.reg_write &&
                     (src_hit(id_use_rs, id_rs, ex_q.rd) || src_hit(id_use_rt, id_rt, ex_q.rd))) ||
                    (exm_reg_write &&
                     (src_hit(id_use_rs, id_rs, exm_rd) || src_hit(id_use_rt, id_rt, exm_rd)));
`endif

    assign id_stall     = id_valid && (hold || hazard);
    assign alu_a        = rs_op;
    assign alu_b        = ex_q.use_imm ? ex_q.imm : rt_op;
    assign ex_store_val = rt_op;
    assign alu_op       = ex_q.op;
    assign alu_is_sign  = ex_q.is_sign;
    assign ex_valid     = ex_q.valid;
    assign ex_rd        = ex_q.rd;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;

endmodule
